// File: rtl/rmii_pkg.sv
// Shared RMII definitions for the receive and transmit converters.
package rmii_pkg;

  typedef enum logic [2:0] {
    ST_DISCARD,
    ST_IDLE,
    ST_ALIGN,
    ST_DATA,
    ST_FLUSH
  } rmii_rx_state_t;

  localparam logic [1:0] RMII_DIBIT_IDLE      = 2'b00;
  localparam int         RMII_DIBITS_PER_BYTE = 4;

endpackage

// File: rtl/rmii_to_axis_shifter.sv
// Dibit-to-byte assembler: LSB dibit first, byte-complete strobe on the 4th dibit.
module rmii_dibit_shifter
  import rmii_pkg::*;
(
  input  logic       clock,
  input  logic       i_clear,
  input  logic       i_shift,
  input  logic [1:0] i_dibit,
  output logic [1:0] o_count,
  output logic [7:0] o_byte,
  output logic       o_done
);

  localparam logic [1:0] LAST_IDX = 2'(RMII_DIBITS_PER_BYTE - 1);

  logic [1:0] r_count;
  logic [7:0] r_byte;
  logic [7:0] w_byte;

  // o_byte already includes the dibit being sampled, so it is complete with o_done
  always_comb begin
    w_byte = r_byte;
    w_byte[{r_count, 1'b0} +: 2] = i_dibit;
  end

  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_count <= 2'd0;
    end else if (i_shift) begin
      r_count <= r_count + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (i_shift) begin
      r_byte <= w_byte;
    end
  end

  assign o_count = r_count;
  assign o_byte  = w_byte;
  assign o_done  = i_shift && (r_count == LAST_IDX);

endmodule

// File: rtl/rmii_to_axis.sv
// RMII receive to 8-bit AXI4-Stream; one pending byte lets tlast ride on the final beat.
module rmii_to_axis (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rmii_d,
  input  logic       rmii_crs_dv,
  input  logic       rmii_er,
  output logic [7:0] maxis_tdata,
  output logic       maxis_tvalid,
  input  logic       maxis_tready,
  output logic       maxis_tlast,
  output logic       maxis_tuser
);
  import rmii_pkg::*;

  rmii_rx_state_t r_state;
  rmii_rx_state_t w_state_nxt;

  logic [7:0] r_pend;
  logic       r_pend_vld;
  logic       r_err;

  logic       w_shift;
  logic       w_clear;
  logic       w_done;
  logic [1:0] w_count;
  logic [7:0] w_byte;
  logic       w_free;
  logic       w_load;
  logic       w_load_last;
  logic       w_load_user;
  logic       w_err_clr;
  logic       w_err_set;

  assign w_free  = !maxis_tvalid || maxis_tready;
  assign w_shift = rmii_crs_dv &&
                   ((r_state == ST_ALIGN && rmii_d != RMII_DIBIT_IDLE) || r_state == ST_DATA);
  assign w_clear = reset || !(r_state == ST_ALIGN || r_state == ST_DATA);

  rmii_dibit_shifter u_shifter (
    .clock   (clock),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_dibit (rmii_d),
    .o_count (w_count),
    .o_byte  (w_byte),
    .o_done  (w_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_DISCARD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_load_user = 1'b0;
    w_err_clr   = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      ST_DISCARD: begin
        if (!rmii_crs_dv) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (rmii_crs_dv) begin
          w_state_nxt = ST_ALIGN;
          w_err_clr   = 1'b1;
        end
      end
      ST_ALIGN: begin
        if (!rmii_crs_dv) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_err_set = rmii_er;
          if (w_shift) w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rmii_crs_dv) begin
          w_err_set = rmii_er;
          if (w_done && r_pend_vld) begin
            // a full output register means this byte is lost: flag the frame
            if (w_free) w_load = 1'b1;
            else        w_err_set = 1'b1;
          end
        end else begin
          w_err_set = rmii_er || (w_count != 2'd0);
          if (!r_pend_vld) begin
            w_state_nxt = ST_IDLE;
          end else if (w_free) begin
            w_load      = 1'b1;
            w_load_last = 1'b1;
            w_load_user = r_err || w_err_set;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_last = 1'b1;
          w_load_user = r_err;
          w_state_nxt = rmii_crs_dv ? ST_DISCARD : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_DISCARD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_err_clr)      r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (w_err_clr)      r_pend_vld <= 1'b0;
      else if (w_done)    r_pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_done) r_pend <= w_byte;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      maxis_tvalid <= 1'b0;
      maxis_tdata  <= 8'd0;
      maxis_tlast  <= 1'b0;
      maxis_tuser  <= 1'b0;
    end else if (w_load) begin
      maxis_tvalid <= 1'b1;
      maxis_tdata  <= r_pend;
      maxis_tlast  <= w_load_last;
      maxis_tuser  <= w_load_user;
    end else if (maxis_tready) begin
      maxis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/rmii_to_axis.md
# rmii_to_axis

Receive-side RMII-to-AXI4-Stream converter, the counterpart of `axis_to_rmii`. It samples 2-bit RMII receive dibits, byte-aligns on the first preamble dibit, and assembles bytes LSB-dibit first. Bytes are emitted on an 8-bit AXI4-Stream master with `tlast` on the final byte of each frame and `tuser` flagging errored frames. Preamble and SFD bytes are forwarded unmodified, so that `axis_to_rmii` → `rmii_to_axis` loopback is byte-transparent.

## Interface
- No parameters.
- `clock` in 1: RMII 50 MHz reference clock; one dibit per cycle.
- `reset` in 1: synchronous, active-high.
- `rmii_d` in 2: receive dibit.
- `rmii_crs_dv` in 1: carrier/data valid, treated as pure data-valid; frame ends on the first cycle it is sampled low.
- `rmii_er` in 1: receive error.
- `maxis_tdata` out 8: received byte.
- `maxis_tvalid` out 1: output beat valid.
- `maxis_tready` in 1: downstream ready.
- `maxis_tlast` out 1: last byte of frame.
- `maxis_tuser` out 1: frame error; meaningful only on the `tlast` beat.

## Operation
- **States:** DISCARD, IDLE, ALIGN, DATA, FLUSH.
- **DISCARD** (state after reset): wait for `crs_dv`=0, then go to IDLE. This ignores any frame already in progress when reset is released.
- **IDLE:** when `crs_dv`=1, go to ALIGN.
- **ALIGN:**
  - `crs_dv`=1 and `rmii_d`=2'b00: discard the dibit.
  - `crs_dv`=1 and `rmii_d`≠2'b00: this dibit is dibit 0 of byte 0; go to DATA with dibit count 1.
  - `crs_dv`=0: go to IDLE and emit nothing.
- **DATA:**
  - Byte assembly: the dibit sampled at count k goes to byte bits [2k+1:2k], for k = 0..3.
  - Byte complete (count wraps 3→0): if a pending byte exists, push it as a non-last beat. The new byte then becomes pending.
  - `crs_dv`=0 sampled: go to FLUSH.
    - If a pending byte exists, it is pushed with `tlast`=1.
    - If no complete byte was received, go to IDLE and emit nothing.
    - Dibit count ≠ 0 (dribble): the partial byte is discarded and the error flag is set.
- **Error flag:** sticky per frame. Set by:
  - `rmii_er`=1 in ALIGN or DATA;
  - dribble;
  - overflow (below).
  
  The flag is cleared on entry to ALIGN and drives `tuser` on the `tlast` beat.
- **Output register:** a single register holding `tdata`/`tlast`/`tuser`.
  - A push while `tvalid`=1 and `tready`=0 in DATA is an overflow. The pushed byte is dropped, the register keeps its content, and the error flag is set.
- **FLUSH:** holds the final beat until the output register is free, loads it, then goes to IDLE.
  - If `crs_dv`=1 in FLUSH, that input is ignored. IPG guarantees at least 48 cycles.
  - If `crs_dv`=1 when FLUSH exits, go to DISCARD instead of IDLE.
- **Reset mid-frame:** all state is cleared and the partial frame is never emitted.

## Timing
- **Reset values:** `maxis_tvalid`=0, `maxis_tdata`=0, `maxis_tlast`=0, `maxis_tuser`=0. The internal state is DISCARD.
- **Inputs** are registered only through the state machine; there is no extra input pipeline.
- **Latency, non-last byte N:** `tvalid` rises the cycle after the 4th dibit of byte N+1 is sampled.
- **Latency, last byte:** `tvalid` rises the cycle after `crs_dv`=0 is first sampled, provided the register is free.
- **Handshake:**
  - `tvalid`/`tdata`/`tlast`/`tuser` are stable while `tvalid`=1 and `tready`=0.
  - `tvalid` drops the cycle after a handshake, unless a push happens in that same cycle; in that case the new beat is loaded with `tvalid` held high.
- **Back-pressure tolerance:** the beat rate is 1 per 4 cycles, so downstream may stall up to 3 cycles per beat with no loss.

## Structure
- **Package `rmii_pkg`:**
  - state enum `rmii_rx_state_t`;
  - `RMII_DIBIT_IDLE` = 2'b00;
  - `RMII_DIBITS_PER_BYTE` = 4.
  
  `axis_to_rmii` shares this package.
- **Sub-module `rmii_dibit_shifter`:** dibit count, byte assembly and the byte-complete strobe, with a synchronous clear.
- The state machine, pending byte and output register stay in the top level.

## Test plan
- **Clean frame:** `crs_dv`=1 with two dibits 00, then the dibits for bytes 55 55 d5 ab cd, then `crs_dv`=0, with `tready`=1 → beats 55, 55, d5, ab, cd. `tlast`=1 only on cd, `tuser`=0, and cd is valid 1 cycle after `crs_dv` falls.
- **Single-byte frame and zero-byte frame:**
  - Single-byte frame, byte ef → one beat ef with `tlast`=1.
  - A `crs_dv` pulse of 3 dibits after alignment → no output beat.
- **Errors:**
  - `rmii_er`=1 for one cycle mid-frame in 55 55 d5 ab cd ef → all 6 beats emitted, ef has `tlast`=1 and `tuser`=1.
  - Dribble: 2 extra dibits after ef → 6 beats, `tuser`=1.
- **Back-pressure:**
  - `tready` low for 3 cycles per beat → all bytes intact, `tuser`=0.
  - `tready` held low for 10 cycles mid-frame → subsequent bytes dropped and `tlast` beat has `tuser`=1.
- **Reset:**
  - `reset` asserted mid-frame → outputs go to 0 the next cycle; after release with `crs_dv` still high, no beat is produced until `crs_dv` goes low and a new frame arrives.
  - Back-to-back frames separated by 48 idle cycles are both received correctly.
